// File: rtl/bp_fe_nonsynth_pkg.sv
// bp_fe_nonsynth_pkg: shared drain modes, FSM states and LFSR taps for the fetch checker
package bp_fe_nonsynth_pkg;
  typedef enum logic [1:0] {e_chk_immediate, e_chk_fixed, e_chk_random, e_chk_stall} bp_fe_chk_mode_e;
  typedef enum logic [1:0] {e_idle, e_delay, e_ready} bp_fe_chk_state_e;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] lfsr_taps_gc = 16'hB400;
endpackage

// File: rtl/bp_fe_nonsynth_chk_lfsr.sv
// bp_fe_nonsynth_chk_lfsr: 16-bit Fibonacci LFSR that steps only when advance_i is high
module bp_fe_nonsynth_chk_lfsr
  import bp_fe_nonsynth_pkg::*;
#(
  parameter int          width_p = 4,
  parameter logic [15:0] seed_p  = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               advance_i,
  output logic [width_p-1:0] lfsr_o
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = advance_i ? {lfsr_q[14:0], ^(lfsr_q & lfsr_taps_gc)} : lfsr_q;
  assign lfsr_o = lfsr_q[width_p-1:0];
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) lfsr_q <= seed_p;
    else lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/bp_fe_nonsynth_fetch_checker.sv
// bp_fe_nonsynth_fetch_checker: captures DUT output, drains with selectable backpressure, compares in order
module bp_fe_nonsynth_fetch_checker
  import bp_fe_nonsynth_pkg::*;
#(
  parameter int          data_width_p  = 32,
  parameter int          els_p         = 16,
  parameter int          delay_width_p = 4,
  parameter logic [15:0] lfsr_seed_p   = 16'hACE1,
  parameter int          timeout_p     = 1024,
  parameter int          cnt_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [1:0]               mode_i,
  input  logic [delay_width_p-1:0] fixed_delay_i,
  input  logic [data_width_p-1:0]  dut_data_i,
  input  logic                     dut_v_i,
  output logic                     dut_ready_o,
  input  logic [data_width_p-1:0]  exp_data_i,
  input  logic                     exp_v_i,
  output logic                     exp_yumi_o,
  output logic                     mismatch_o,
  output logic                     error_o,
  output logic [cnt_width_p-1:0]   match_cnt_o,
  output logic [cnt_width_p-1:0]   mismatch_cnt_o,
  output logic [$clog2(els_p):0]   occupancy_o,
  output logic                     timeout_o
);
  localparam int aw = $clog2(els_p);
  localparam int pw = aw + 1;
  localparam int tw = $clog2(timeout_p + 1);
  localparam logic [tw-1:0] to_lim = tw'(timeout_p);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [pw-1:0] wptr_q, wptr_d, rptr_q, rptr_d, occ_q, occ_d;
  logic [delay_width_p-1:0] delay_q, delay_d, load_delay, lfsr_delay;
  logic [cnt_width_p-1:0] match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic [tw-1:0] tcnt_q, tcnt_d;
  logic mismatch_q, mismatch_d, error_q, error_d, timeout_q, timeout_d;
  logic full, empty, push, pop, eq, remain, load, advance;
  bp_fe_chk_state_e state_q, state_d;
  bp_fe_chk_mode_e mode;

  assign mode        = bp_fe_chk_mode_e'(mode_i);
  assign full        = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
  assign empty       = wptr_q == rptr_q;
  assign push        = dut_v_i & ~full;
  assign pop         = (state_q == e_ready) & exp_v_i;
  assign eq          = mem_q[rptr_q[aw-1:0]] == exp_data_i;
  assign remain      = (occ_q > pw'(1)) | push;
  assign load_delay  = mode == e_chk_fixed ? fixed_delay_i : mode == e_chk_random ? lfsr_delay : '0;
  // a load happens on first arrival in idle, or back-to-back after a pop that leaves entries
  assign load        = ((state_q == e_idle && !empty) || (pop && remain)) && mode != e_chk_stall;
  assign advance     = load && mode == e_chk_random;

  assign dut_ready_o    = ~full;
  assign exp_yumi_o     = pop;
  assign mismatch_o     = mismatch_q;
  assign error_o        = error_q;
  assign match_cnt_o    = match_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign occupancy_o    = occ_q;
  assign timeout_o      = timeout_q;

  bp_fe_nonsynth_chk_lfsr #(.width_p(delay_width_p), .seed_p(lfsr_seed_p)) lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .advance_i (advance),
    .lfsr_o    (lfsr_delay)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    if (load) begin
      delay_d = load_delay;
      state_d = load_delay != '0 ? e_delay : e_ready;
    end else if (state_q == e_delay) begin
      delay_d = delay_q - delay_width_p'(1);
      state_d = delay_q == delay_width_p'(1) ? e_ready : e_delay;
    end else if (pop) begin
      state_d = e_idle;
    end
  end

  always_comb begin
    wptr_d         = wptr_q + pw'(push);
    rptr_d         = rptr_q + pw'(pop);
    occ_d          = occ_q + pw'(push) - pw'(pop);
    match_cnt_d    = match_cnt_q + cnt_width_p'(pop & eq & ~&match_cnt_q);
    mismatch_cnt_d = mismatch_cnt_q + cnt_width_p'(pop & ~eq & ~&mismatch_cnt_q);
    mismatch_d     = pop & ~eq;
    error_d        = error_q | mismatch_d;
    tcnt_d         = (push || pop || mode == e_chk_stall) ? '0
                   : ((!empty || exp_v_i) && tcnt_q != to_lim) ? tcnt_q + tw'(1) : tcnt_q;
    timeout_d      = timeout_q | (tcnt_d == to_lim);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[aw-1:0]] <= dut_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      occ_q          <= '0;
      state_q        <= e_idle;
      delay_q        <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      mismatch_q     <= 1'b0;
      error_q        <= 1'b0;
      tcnt_q         <= '0;
      timeout_q      <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      occ_q          <= occ_d;
      state_q        <= state_d;
      delay_q        <= delay_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      mismatch_q     <= mismatch_d;
      error_q        <= error_d;
      tcnt_q         <= tcnt_d;
      timeout_q      <= timeout_d;
    end
  end
endmodule

// File: tb/tb_bp_fe_nonsynth_fetch_checker.sv
// tb_bp_fe_nonsynth_fetch_checker: directed scenario checks for the fetch checker
module tb_bp_fe_nonsynth_fetch_checker;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  fixed_delay = 4'd0;
  logic [31:0] dut_data = '0;
  logic        dut_v = 1'b0;
  logic        dut_ready;
  logic [31:0] exp_data = '0;
  logic        exp_v = 1'b0;
  logic        exp_yumi, mismatch, error, timeout;
  logic [15:0] match_cnt, mismatch_cnt;
  logic [4:0]  occupancy;
  int checks = 0;
  int errors = 0;
  int pop_t [2][32];
  int gold [32];

  bp_fe_nonsynth_fetch_checker #(.timeout_p(8)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .mode_i         (mode),
    .fixed_delay_i  (fixed_delay),
    .dut_data_i     (dut_data),
    .dut_v_i        (dut_v),
    .dut_ready_o    (dut_ready),
    .exp_data_i     (exp_data),
    .exp_v_i        (exp_v),
    .exp_yumi_o     (exp_yumi),
    .mismatch_o     (mismatch),
    .error_o        (error),
    .match_cnt_o    (match_cnt),
    .mismatch_cnt_o (mismatch_cnt),
    .occupancy_o    (occupancy),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; dut_v = 1'b0; exp_v = 1'b0; mode = 2'd0;
    tick;
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if ({exp_yumi, mismatch, error, timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {exp_yumi, mismatch, error, timeout}); end
    checks++; if ({match_cnt, mismatch_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnts got %0h want 0", {match_cnt, mismatch_cnt}); end
    reset_n = 1'b1;
    #1;
    checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", dut_ready); end
  endtask

  task automatic test_in_order;
    logic [31:0] vals [3];
    int idx = 0;
    int yums = 0;
    logic got;
    vals = '{32'h13, 32'h93, 32'h113};
    do_reset;
    for (int i = 0; i < 3; i++) begin dut_v = 1'b1; dut_data = vals[i]; tick; end
    dut_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_v = idx < 3;
      exp_data = vals[idx < 3 ? idx : 2];
      #1;
      got = exp_yumi;
      yums += int'(got);
      tick;
      if (got) idx++;
    end
    exp_v = 1'b0;
    checks++; if (yums !== 3) begin errors++; $display("FAIL inorder_yumis got %0d want 3", yums); end
    checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL inorder_match got %0d want 3", match_cnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL inorder_error got %b want 0", error); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL inorder_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_fixed_delay;
    int first = -1;
    int n = 0;
    logic got;
    do_reset;
    mode = 2'd1; fixed_delay = 4'd3;
    exp_v = 1'b1; exp_data = 32'hDEAD_BEEF;
    dut_v = 1'b1; dut_data = 32'hDEAD_BEEF;
    tick;
    dut_v = 1'b0;
    for (int c = 0; c < 10; c++) begin
      got = exp_yumi;
      if (got && first < 0) first = c;
      n += int'(got);
      tick;
      if (got) exp_v = 1'b0;
    end
    exp_v = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL fixed_yumi_cycle got %0d want 4", first); end
    checks++; if (n !== 1) begin errors++; $display("FAIL fixed_yumi_count got %0d want 1", n); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL fixed_match got %0d want 1", match_cnt); end
  endtask

  task automatic test_full_stall;
    int idx = 0;
    int first = -1;
    int last = -1;
    int n = 0;
    logic got;
    do_reset;
    mode = 2'd3;
    for (int i = 0; i < 16; i++) begin dut_v = 1'b1; dut_data = 32'h100 + i; tick; end
    checks++; if (dut_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", dut_ready); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ got %0d want 16", occupancy); end
    dut_data = 32'hBAD;
    tick;
    dut_v = 1'b0;
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_drop_occ got %0d want 16", occupancy); end
    repeat (12) tick;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", timeout); end
    mode = 2'd0;
    for (int c = 0; c < 24; c++) begin
      exp_v = idx < 16;
      exp_data = 32'h100 + idx;
      #1;
      got = exp_yumi;
      if (got) begin if (first < 0) first = c; last = c; n++; end
      tick;
      if (got) idx++;
    end
    exp_v = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL drain_count got %0d want 16", n); end
    checks++; if (last - first !== 15) begin errors++; $display("FAIL drain_span got %0d want 15", last - first); end
    checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", dut_ready); end
    checks++; if (match_cnt !== 16'd16) begin errors++; $display("FAIL drain_match got %0d want 16", match_cnt); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL drain_mismatch got %0d want 0", mismatch_cnt); end
  endtask

  task automatic test_mismatch;
    int yc = -1;
    int mc = -1;
    int mn = 0;
    logic got;
    do_reset;
    dut_v = 1'b1; dut_data = 32'h1;
    exp_v = 1'b1; exp_data = 32'h2;
    tick;
    dut_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      got = exp_yumi;
      if (got && yc < 0) yc = c;
      if (mismatch) begin if (mc < 0) mc = c; mn++; end
      tick;
      if (got) exp_v = 1'b0;
    end
    checks++; if (mc !== yc + 1) begin errors++; $display("FAIL mismatch_pulse_cycle got %0d want %0d", mc, yc + 1); end
    checks++; if (mn !== 1) begin errors++; $display("FAIL mismatch_pulse_len got %0d want 1", mn); end
    checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_cnt got %0d want 1", mismatch_cnt); end
    dut_v = 1'b1; dut_data = 32'h5;
    exp_v = 1'b1; exp_data = 32'h5;
    tick;
    dut_v = 1'b0;
    repeat (4) tick;
    exp_v = 1'b0;
    tick;
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_then_match got %0d want 1", match_cnt); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got %b want 1", error); end
    checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_cnt_hold got %0d want 1", mismatch_cnt); end
  endtask

  task automatic test_timeout;
    do_reset;
    dut_v = 1'b1; dut_data = 32'h77;
    tick;
    dut_v = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (k == 7) begin checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", timeout); end end
      if (k == 8) begin checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", timeout); end end
    end
    repeat (3) tick;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_held got %b want 1", timeout); end
    reset_n = 1'b0;
    tick;
    checks++; if ({exp_yumi, mismatch, error, timeout} !== 4'b0) begin errors++; $display("FAIL rst_mid_flags got %b want 0000", {exp_yumi, mismatch, error, timeout}); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_mid_occ got %0d want 0", occupancy); end
    checks++; if ({match_cnt, mismatch_cnt} !== 32'd0) begin errors++; $display("FAIL rst_mid_cnts got %0h want 0", {match_cnt, mismatch_cnt}); end
    reset_n = 1'b1;
    #1;
    checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", dut_ready); end
  endtask

  task automatic run_random(input int r);
    int idx = 0;
    int guard;
    logic got;
    for (int k = 0; k < 32; k++) pop_t[r][k] = -1;
    do_reset;
    mode = 2'd2;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          dut_v = 1'b1;
          dut_data = 32'hC0DE_0000 + i;
          guard = 0;
          while (!dut_ready && guard < 200) begin tick; guard++; end
          tick;
        end
        dut_v = 1'b0;
      end
      begin
        tick;
        for (int c = 0; c < 700 && idx < 32; c++) begin
          exp_v = 1'b1;
          exp_data = 32'hC0DE_0000 + idx;
          #1;
          got = exp_yumi;
          if (got) pop_t[r][idx] = c;
          tick;
          if (got) idx++;
        end
        exp_v = 1'b0;
      end
    join
    checks++; if (match_cnt !== 16'd32) begin errors++; $display("FAIL random_match run%0d got %0d want 32", r, match_cnt); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL random_mismatch run%0d got %0d want 0", r, mismatch_cnt); end
  endtask

  task automatic test_random;
    logic [15:0] l = 16'hACE1;
    int t = 0;
    int diffs = 0;
    for (int k = 0; k < 32; k++) begin
      t = t + 1 + int'(l[3:0]);
      gold[k] = t;
      l = lfsr_next(l);
    end
    run_random(0);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (pop_t[0][k] !== gold[k]) begin errors++; $display("FAIL random_pop%0d got %0d want %0d", k, pop_t[0][k], gold[k]); end
    end
    run_random(1);
    for (int k = 0; k < 32; k++) if (pop_t[1][k] !== gold[k]) diffs++;
    checks++; if (diffs !== 0) begin errors++; $display("FAIL random_rerun differing pops got %0d want 0", diffs); end
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_fixed_delay;
    test_full_stall;
    test_mismatch;
    test_timeout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
